// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost flags and overflow/underflow pulses.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo_param #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int ALM_FULL_TH  = 2,
  parameter int ALM_EMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  i_wrdata,
  input  logic              i_wren,
  input  logic              i_rden,
  output logic [WIDTH-1:0]  o_rddata,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LEVEL   = (ADDR_W+1)'(DEPTH - ALM_FULL_TH);
  localparam logic [ADDR_W:0] AE_LEVEL   = (ADDR_W+1)'(ALM_EMPTY_TH);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              rd_acc;
  logic              wr_acc;

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc     = i_rden & ~o_empty;
    wr_acc     = i_wren & (~o_full | rd_acc);
    count_next = count;
    if (wr_acc & ~rd_acc)
      count_next = count + CNT_ONE;
    else if (rd_acc & ~wr_acc)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_full  <= 1'b0;
      o_alm_empty <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      count       <= count_next;
      o_full      <= (count_next == FULL_LEVEL);
      o_empty     <= (count_next == '0);
      o_alm_full  <= (count_next >= AF_LEVEL);
      o_alm_empty <= (count_next <= AE_LEVEL);
      o_overflow  <= i_wren & ~wr_acc;
      o_underflow <= i_rden & ~rd_acc;
    end
  end

  // Storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= i_wrdata;
  end

  assign o_count = count;

`ifdef SYN_FIFO_FWFT_EN
  assign o_rd_valid = ~o_empty;
  assign o_rddata   = o_empty ? '0 : mem[rd_ptr];
`else
  // Same-address write and read only happens when full, so the old word is returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rddata   <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= rd_acc;
      if (rd_acc)
        o_rddata <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 2;
  localparam int AE    = 2;
  localparam int VW    = AW + 1 + 7 + WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] i_wrdata;
  logic             i_wren;
  logic             i_rden;
  logic [WIDTH-1:0] o_rddata;
  logic             o_rd_valid;
  logic             o_full;
  logic             o_empty;
  logic             o_alm_full;
  logic             o_alm_empty;
  logic [AW:0]      o_count;
  logic             o_overflow;
  logic             o_underflow;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALM_FULL_TH(AF), .ALM_EMPTY_TH(AE)
  ) dut (
    .clk(clk), .reset(reset), .i_wrdata(i_wrdata), .i_wren(i_wren), .i_rden(i_rden),
    .o_rddata(o_rddata), .o_rd_valid(o_rd_valid), .o_full(o_full), .o_empty(o_empty),
    .o_alm_full(o_alm_full), .o_alm_empty(o_alm_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_rddata;
  logic             exp_rdvalid;
  logic             exp_ovf;
  logic             exp_udf;

  logic [VW-1:0] obs_vec;
  assign obs_vec = {o_count, o_full, o_empty, o_alm_full, o_alm_empty,
                    o_rd_valid, o_overflow, o_underflow, o_rddata};

  // Expected output vector derived from the model occupancy and last model events.
  function automatic logic [VW-1:0] exp_vec();
    int n;
    n = model_q.size();
    return {(AW+1)'(n), (n == DEPTH), (n == 0), (n >= DEPTH - AF), (n <= AE),
            exp_rdvalid, exp_ovf, exp_udf, exp_rddata};
  endfunction

  task automatic model_reset();
    model_q.delete();
    exp_rddata  = '0;
    exp_rdvalid = 1'b0;
    exp_ovf     = 1'b0;
    exp_udf     = 1'b0;
  endtask

  // Drive one cycle of requests, advance the model at the edge, return 1 time unit after it.
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    int   n;
    logic rd_ok;
    logic wr_ok;
    i_wren   = w;
    i_rden   = r;
    i_wrdata = d;
    @(posedge clk);
    n       = model_q.size();
    rd_ok   = r && (n > 0);
    wr_ok   = w && ((n < DEPTH) || rd_ok);
    exp_ovf = w && !wr_ok;
    exp_udf = r && !rd_ok;
`ifndef SYN_FIFO_FWFT_EN
    exp_rdvalid = rd_ok;
    if (rd_ok)
      exp_rddata = model_q[0];
`endif
    if (rd_ok)
      void'(model_q.pop_front());
    if (wr_ok)
      model_q.push_back(d);
`ifdef SYN_FIFO_FWFT_EN
    exp_rdvalid = (model_q.size() > 0);
    exp_rddata  = exp_rdvalid ? model_q[0] : '0;
`endif
    #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL reset_initial: got %h expected %h", obs_vec, exp_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 32'hA1);
    cycle(1'b1, 1'b0, 32'hA2);
    cycle(1'b1, 1'b0, 32'hA3);
    cycle(1'b0, 1'b1, '0);
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL pre_reset_state: got %h expected %h", obs_vec, exp_vec());
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL async_reset: got %h expected %h", obs_vec, exp_vec());
    end
    total++;
    if (o_count !== '0 || o_empty !== 1'b1 || o_alm_empty !== 1'b1 || o_rddata !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset_flags: got count=%0d empty=%b alm_empty=%b data=%h expected 0 1 1 0",
               o_count, o_empty, o_alm_empty, o_rddata);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL post_reset: got %h expected %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, WIDTH'(i));
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL fill_%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (i == 2 || i == 3) begin
        total++;
        if (o_alm_empty !== (i == 2)) begin
          bad++;
          $display("[TB] FAIL fill_alm_empty_%0d: got %b expected %b", i, o_alm_empty, (i == 2));
        end
      end
      if (i == 13 || i == 14) begin
        total++;
        if (o_alm_full !== (i == 14)) begin
          bad++;
          $display("[TB] FAIL fill_alm_full_%0d: got %b expected %b", i, o_alm_full, (i == 14));
        end
      end
    end
    total++;
    if (o_full !== 1'b1 || o_count !== (AW+1)'(DEPTH)) begin
      bad++;
      $display("[TB] FAIL fill_full: got full=%b count=%0d expected 1 16", o_full, o_count);
    end
    cycle(1'b1, 1'b0, 32'h11);
    total++;
    if (o_overflow !== 1'b1 || o_count !== (AW+1)'(DEPTH) || obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL overflow: got ovf=%b count=%0d expected 1 16", o_overflow, o_count);
    end
    cycle(1'b0, 1'b0, '0);
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_pulse: got %b expected 0", o_overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL drain_%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
`ifndef SYN_FIFO_FWFT_EN
      total++;
      if (o_rd_valid !== 1'b1 || o_rddata !== WIDTH'(i)) begin
        bad++;
        $display("[TB] FAIL drain_data_%0d: got valid=%b data=%h expected 1 %h", i, o_rd_valid, o_rddata, WIDTH'(i));
      end
`endif
    end
    total++;
    if (o_empty !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_empty: got %b expected 1", o_empty);
    end
    cycle(1'b0, 1'b1, '0);
    total++;
    if (o_underflow !== 1'b1 || o_rd_valid !== 1'b0 || obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL underflow: got udf=%b valid=%b expected 1 0", o_underflow, o_rd_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] head_word;
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 1'b0, WIDTH'($urandom));
    head_word = model_q[0];
    cycle(1'b1, 1'b1, 32'hAA);
    total++;
    if (obs_vec !== exp_vec() || o_count !== (AW+1)'(DEPTH) || o_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL simul_full: got %h expected %h", obs_vec, exp_vec());
    end
`ifndef SYN_FIFO_FWFT_EN
    total++;
    if (o_rddata !== head_word) begin
      bad++;
      $display("[TB] FAIL simul_full_head: got %h expected %h", o_rddata, head_word);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL simul_drain_%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    cycle(1'b1, 1'b1, 32'h77);
    total++;
    if (obs_vec !== exp_vec() || o_count !== (AW+1)'(1) || o_underflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL simul_empty: got count=%0d udf=%b expected 1 1", o_count, o_underflow);
    end
    cycle(1'b0, 1'b1, '0);
  endtask

  task automatic test_wrap();
    int   n;
    logic w;
    logic r;
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, WIDTH'($urandom));
    for (int i = 0; i < 40; i++) begin
      n = model_q.size();
      w = (n <= 3) ? 1'b1 : ((n >= 9) ? 1'b0 : 1'($urandom));
      r = (n >= 9) ? 1'b1 : ((n <= 3) ? 1'b0 : 1'($urandom));
      cycle(w, r, WIDTH'($urandom));
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL wrap_%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    while (model_q.size() > 0)
      cycle(1'b0, 1'b1, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'(($urandom % 100) < 55), 1'(($urandom % 100) < 45), WIDTH'($urandom));
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    while (model_q.size() > 0)
      cycle(1'b0, 1'b1, '0);
  endtask

`ifdef SYN_FIFO_FWFT_EN
  task automatic test_fwft();
    cycle(1'b1, 1'b0, 32'h55);
    total++;
    if (o_rd_valid !== 1'b1 || o_rddata !== 32'h55) begin
      bad++;
      $display("[TB] FAIL fwft_first: got valid=%b data=%h expected 1 55", o_rd_valid, o_rddata);
    end
    cycle(1'b0, 1'b1, '0);
    total++;
    if (o_empty !== 1'b1 || o_rd_valid !== 1'b0 || obs_vec !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL fwft_pop: got empty=%b valid=%b expected 1 0", o_empty, o_rd_valid);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting sync_fifo_param bench");
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
`ifdef SYN_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; the next generation of the team's SYN_FIFO.
- Adds configurable width/depth, programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow pulses and a read-valid strobe.
- Full/empty are exact for any power-of-two depth.
- Sits between a producer and a consumer in the same clock domain; drop-in for the fixed-size FIFO, which uses the same i_/o_ port prefixes.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.
- ALM_FULL_TH, 2, o_alm_full asserts when free entries <= ALM_FULL_TH.
- ALM_EMPTY_TH, 2, o_alm_empty asserts when occupancy <= ALM_EMPTY_TH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_wrdata  input  WIDTH  write data.
- i_wren  input  1  write request.
- i_rden  input  1  read request.
- o_rddata  output  WIDTH  read data.
- o_rd_valid  output  1  o_rddata holds a valid popped word.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_alm_full  output  1  almost full.
- o_alm_empty  output  1  almost empty.
- o_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  one-cycle pulse: write request rejected.
- o_underflow  output  1  one-cycle pulse: read request rejected.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high: wr_ptr, rd_ptr and count = 0; o_empty = 1; o_alm_empty = 1; o_full, o_alm_full, o_rd_valid, o_overflow and o_underflow = 0; o_rddata = 0. Storage array is not reset. Reset mid-operation discards all contents; first write after deassertion lands at address 0.
- Acceptance, evaluated on the registered flags at the clock edge:
  - rd_acc = i_rden & !o_empty.
  - wr_acc = i_wren & (!o_full | rd_acc). Simultaneous write and read on a full FIFO are both accepted; count stays DEPTH.
  - Write and read on an empty FIFO: only the write is accepted; o_underflow pulses.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. Count is a separate ADDR_W+1 register: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Flags are registered and computed from next-count, so they are valid in the same cycle as o_count:
  - o_full = (count == DEPTH); o_empty = (count == 0).
  - o_alm_full = (count >= DEPTH-ALM_FULL_TH); o_alm_empty = (count <= ALM_EMPTY_TH).
- Read latency 1: on rd_acc, mem[rd_ptr] is registered into o_rddata and o_rd_valid is high for the next cycle only. Otherwise o_rd_valid = 0 and o_rddata holds its last value.
- Memory write: mem[wr_ptr] <= i_wrdata on wr_acc. Same-address read and write in one cycle can only happen when full, so a read returns the old word.
- o_overflow = registered (i_wren & !wr_acc). o_underflow = registered (i_rden & !rd_acc). Each is a single-cycle pulse per rejected request. A rejected request has no other effect.

Optional Feature:
- Macro: SYN_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - o_rddata presents the head entry whenever the FIFO is non-empty.
  - o_rd_valid = !o_empty, as a level.
  - i_rden acts as an acknowledge: it pops the head, and the next entry (if any) appears on the following cycle.
  - Latency from the first write into an empty FIFO to o_rd_valid is 1 cycle.
  - Underflow rules are unchanged.
- Undefined: standard mode with 1-cycle read latency and a pulsed o_rd_valid, as above.

Test Plan (WIDTH=32, DEPTH=16, thresholds=2):
- Reset/flags: assert reset asynchronously mid-clock -> outputs reach reset values immediately, with no clock edge required; o_empty=1, o_alm_empty=1, o_count=0.
- Fill: write 0x1..0x10 on consecutive cycles -> o_alm_empty drops after the 3rd write; o_alm_full rises at count 14; o_full=1 at count 16; a 17th write gives o_overflow=1 for one cycle and count stays 16.
- Drain: from full, read 16 times -> o_rddata sequence 0x1..0x10, each 1 cycle after its rden with o_rd_valid=1; o_empty=1 after the last read; a 17th read gives o_underflow=1 and o_rd_valid=0.
- Simultaneous: at count 16, assert wren(0xAA)+rden -> both accepted, count 16, head word popped; at count 0, wren+rden -> count 1, o_underflow=1.
- Wrap: 40 interleaved writes and reads keeping count between 3 and 9 -> data order preserved across pointer wrap; o_count matches the scoreboard every cycle.
- FWFT (macro defined): single write 0x55 into an empty FIFO -> next cycle o_rd_valid=1 and o_rddata=0x55; assert rden -> o_empty=1 the following cycle.
